dmem_arbiter: RTL and testbench

Sequential arbiter that shares the single-port `data_mem` between the cirno core's `ld`/`st` path and a host/debug port used to preload and dump data memory. It sits between the `cirno` sequencer and `data_mem` and owns the `memory_r_en`/`memory_w_en`/address/write-data lines. It grants one access at a time with a fixed three-state FSM, round-robin (or host-priority) selection, and a host lock for bursts.

---
 rtl/cirno_pkg.sv | 16 +
 rtl/rr_pick.sv | 33 +++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cirno_pkg.sv
// Shared definitions for the cirno data-memory arbiter.
package cirno_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way request picker: round-robin on `last`, or host-first when HOST_PRIO
// is set, with optional exclusion of the port that was just served.
module rr_pick
    import cirno_pkg::*;
#(
    parameter int unsigned HOST_PRIO = 0
) (
    input  logic core_elig,
    input  logic host_elig,
    input  logic last,
    input  logic excl_en,
    input  logic excl,
    output logic win,
    output logic valid
);

    logic core_ok;
    logic host_ok;

    // Mask the excluded port, then resolve ties by policy.
    always_comb begin
        core_ok = core_elig && !(excl_en && (excl == OWN_CORE));
        host_ok = host_elig && !(excl_en && (excl == OWN_HOST));
        valid   = core_ok || host_ok;
        win     = OWN_CORE;
        if (core_ok && host_ok) begin
            win = (HOST_PRIO != 0) ? OWN_HOST : ~last;
        end else if (host_ok) begin
            win = OWN_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core ld/st path
// and the host/debug port, one access at a time (IDLE -> ISSUE -> RESP).
module dmem_arbiter
    import cirno_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned HOST_PRIO = 0
) (
    input  logic              clk,
    input  logic              init,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_r_en,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic              grant;
    logic              last;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] host_hold;
    logic              core_elig;
    logic              pick_win;
    logic              pick_valid;

    assign core_elig = core_req && !host_lock;

    // The same picker serves both decision points; in RESP the owner is excluded.
    rr_pick #(
        .HOST_PRIO(HOST_PRIO)
    ) u_pick (
        .core_elig(core_elig),
        .host_elig(host_req),
        .last     (last),
        .excl_en  (state == RESP),
        .excl     (owner),
        .win      (pick_win),
        .valid    (pick_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge init) begin
        if (init) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and grant decision.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = ISSUE;
                    grant    = 1'b1;
                end
            end
            ISSUE: state_nx = RESP;
            RESP: begin
                grant    = pick_valid;
                state_nx = pick_valid ? ISSUE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winner's request and record ownership on every grant.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            last      <= OWN_HOST;
            owner     <= OWN_CORE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            last  <= pick_win;
            owner <= pick_win;
            if (pick_win == OWN_HOST) begin
                lat_we    <= host_we;
                lat_addr  <= host_addr;
                lat_wdata <= host_wdata;
            end else begin
                lat_we    <= core_we;
                lat_addr  <= core_addr;
                lat_wdata <= core_wdata;
            end
        end
    end

    // Per-port read data hold, captured at the end of a load's RESP cycle.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            core_hold <= '0;
            host_hold <= '0;
        end else if ((state == RESP) && !lat_we) begin
            if (owner == OWN_HOST) host_hold <= mem_out;
            else                   core_hold <= mem_out;
        end
    end

    // Memory strobes, acks and read data; enables exist only in ISSUE.
    always_comb begin
        mem_addr   = lat_addr;
        mem_in     = lat_wdata;
        mem_w_en   = (state == ISSUE) && lat_we;
        mem_r_en   = (state == ISSUE) && !lat_we;
        busy       = (state != IDLE);
        core_ack   = (state == RESP) && (owner == OWN_CORE);
        host_ack   = (state == RESP) && (owner == OWN_HOST);
        core_rdata = (core_ack && !lat_we) ? mem_out : core_hold;
        host_rdata = (host_ack && !lat_we) ? mem_out : host_hold;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// two-master phase scored against a shadow memory and arbitration timing rules.
module tb_dmem_arbiter;

    logic       clk;
    logic       init;
    logic       core_req, core_we, core_ack;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_ack, host_lock;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic [7:0] mem_addr, mem_in, mem_out;
    logic       mem_r_en, mem_w_en, busy, owner;

    logic       p_init;
    logic       p_core_req, p_core_we, p_core_ack;
    logic [7:0] p_core_addr, p_core_wdata, p_core_rdata;
    logic       p_host_req, p_host_we, p_host_ack, p_host_lock;
    logic [7:0] p_host_addr, p_host_wdata, p_host_rdata;
    logic [7:0] p_mem_addr, p_mem_in, p_mem_out;
    logic       p_mem_r_en, p_mem_w_en, p_busy, p_owner;

    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];
    logic [7:0] shadow [256];
    logic [7:0] held [2];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIO(0)) dut (
        .clk(clk), .init(init),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_lock(host_lock), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_out(mem_out),
        .busy(busy), .owner(owner)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIO(1)) dut_prio (
        .clk(clk), .init(p_init),
        .core_req(p_core_req), .core_we(p_core_we), .core_addr(p_core_addr),
        .core_wdata(p_core_wdata), .core_ack(p_core_ack), .core_rdata(p_core_rdata),
        .host_req(p_host_req), .host_we(p_host_we), .host_addr(p_host_addr),
        .host_wdata(p_host_wdata), .host_ack(p_host_ack), .host_rdata(p_host_rdata),
        .host_lock(p_host_lock), .mem_addr(p_mem_addr), .mem_in(p_mem_in),
        .mem_r_en(p_mem_r_en), .mem_w_en(p_mem_w_en), .mem_out(p_mem_out),
        .busy(p_busy), .owner(p_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port data memories: read data valid the cycle after r_en.
    always @(posedge clk) begin
        if (mem_w_en) ram0[mem_addr] <= mem_in;
        if (mem_r_en) mem_out <= ram0[mem_addr];
    end
    always @(posedge clk) begin
        if (p_mem_w_en) ram1[p_mem_addr] <= p_mem_in;
        if (p_mem_r_en) p_mem_out <= ram1[p_mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Always-true rules: enables exclusive and only while busy, acks exclusive.
    always @(negedge clk) begin
        check_eq("inv_en_excl", {31'd0, mem_r_en & mem_w_en}, 0);
        check_eq("inv_en_busy", {31'd0, (mem_r_en | mem_w_en) & ~busy}, 0);
        check_eq("inv_ack_excl", {31'd0, core_ack & host_ack}, 0);
        check_eq("inv_p_en_excl", {31'd0, p_mem_r_en & p_mem_w_en}, 0);
        check_eq("inv_p_ack_excl", {31'd0, p_core_ack & p_host_ack}, 0);
    end

    task automatic drive_port(input bit p, input bit rq, input bit we,
                              input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            host_req = rq; host_we = we; host_addr = a; host_wdata = d;
        end else begin
            core_req = rq; core_we = we; core_addr = a; core_wdata = d;
        end
    endtask

    task automatic do_reset();
        init = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_acks", {core_ack, host_ack}, 0);
        check_eq("rst_enables", {mem_r_en, mem_w_en}, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_in", mem_in, 0);
        check_eq("rst_core_rdata", core_rdata, 0);
        check_eq("rst_host_rdata", host_rdata, 0);
        init = 1'b0;
        held[0] = '0;
        held[1] = '0;
    endtask

    // One access from an idle arbiter: ISSUE next cycle, ack the cycle after.
    task automatic do_access(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d);
        drive_port(p, 1'b1, we, a, d);
        @(negedge clk);
        check_eq("acc_issue_busy", busy, 1);
        check_eq("acc_issue_wen", mem_w_en, we);
        check_eq("acc_issue_ren", mem_r_en, !we);
        check_eq("acc_issue_addr", mem_addr, a);
        check_eq("acc_issue_owner", owner, p);
        check_eq("acc_issue_noack", core_ack | host_ack, 0);
        if (we) check_eq("acc_issue_wdata", mem_in, d);
        @(negedge clk);
        check_eq("acc_ack", p ? host_ack : core_ack, 1);
        check_eq("acc_other_noack", p ? core_ack : host_ack, 0);
        check_eq("acc_resp_enables", {mem_r_en, mem_w_en}, 0);
        if (we) begin
            check_eq("acc_store_rdata", p ? host_rdata : core_rdata, held[p]);
            shadow[a] = d;
        end else begin
            check_eq("acc_load_rdata", p ? host_rdata : core_rdata, shadow[a]);
            held[p] = shadow[a];
        end
        drive_port(p, 1'b0, we, a, d);
        @(negedge clk);
        check_eq("acc_after_noack", core_ack | host_ack, 0);
        check_eq("acc_after_idle", busy, 0);
        check_eq("acc_after_hold", p ? host_rdata : core_rdata, held[p]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         pend [2];
        int         wt [2];
        bit         r_we [2];
        logic [7:0] r_addr [2];
        logic [7:0] r_wdata [2];
        logic [7:0] exp_rd [3];
        logic [7:0] addrs [3];
        logic       a_l;
        logic [7:0] rd_l;
        int         idx;
        int         waited;
        bit         seen;

        init = 1'b1; p_init = 1'b1; host_lock = 1'b0; p_host_lock = 1'b0;
        drive_port(0, 0, 0, 8'h00, 8'h00);
        drive_port(1, 0, 0, 8'h00, 8'h00);
        p_core_req = 0; p_core_we = 1; p_core_addr = 8'h81; p_core_wdata = 8'h11;
        p_host_req = 0; p_host_we = 1; p_host_addr = 8'h80; p_host_wdata = 8'h22;
        @(negedge clk);
        p_init = 1'b0;
        do_reset();

        // Core store then load.
        do_access(0, 1, 8'h10, 8'h5A);
        do_access(0, 0, 8'h10, 8'h00);

        // Preload through the host port.
        do_access(1, 1, 8'h03, 8'h3C);
        for (int i = 0; i < 8; i++) do_access(1, 1, 8'(8'h40 + i), 8'(i * 37 + 5));

        // Simultaneous requests after reset: core first, host two cycles later.
        do_reset();
        drive_port(0, 1, 0, 8'h03, 8'h00);
        drive_port(1, 1, 1, 8'h04, 8'h77);
        @(negedge clk);
        check_eq("sim_owner_core", owner, 0);
        check_eq("sim_core_ren", mem_r_en, 1);
        @(negedge clk);
        check_eq("sim_core_ack", {core_ack, host_ack}, 2'b10);
        check_eq("sim_core_rdata", core_rdata, 8'h3C);
        held[0] = 8'h3C;
        core_req = 1'b0;
        @(negedge clk);
        check_eq("sim_owner_host", owner, 1);
        check_eq("sim_host_wen", mem_w_en, 1);
        check_eq("sim_host_addr", mem_addr, 8'h04);
        check_eq("sim_host_in", mem_in, 8'h77);
        @(negedge clk);
        check_eq("sim_host_ack", {core_ack, host_ack}, 2'b01);
        shadow[8'h04] = 8'h77;
        host_req = 1'b0;
        @(negedge clk);
        check_eq("sim_idle", busy, 0);

        // Both ports continuous: strict alternation, one access every 2 cycles.
        drive_port(0, 1, 0, 8'h10, 8'h00);
        drive_port(1, 1, 0, 8'h04, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_eq("alt_core_ack", core_ack, (k % 4) == 2);
            check_eq("alt_host_ack", host_ack, (k % 4) == 0);
            if (k % 4 == 1) check_eq("alt_owner", owner, 0);
            if (k % 4 == 3) check_eq("alt_owner", owner, 1);
            if (core_ack) check_eq("alt_core_rdata", core_rdata, shadow[8'h10]);
            if (host_ack) check_eq("alt_host_rdata", host_rdata, shadow[8'h04]);
        end
        held[0] = shadow[8'h10];
        held[1] = shadow[8'h04];
        core_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        check_eq("alt_idle", busy, 0);

        // Host lock burst with the core request held throughout.
        host_lock = 1'b1;
        drive_port(0, 1, 0, 8'h22, 8'h00);
        drive_port(1, 1, 1, 8'h20, 8'h01);
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            seen = 1'b0;
            while (!seen && waited < 6) begin
                @(negedge clk);
                waited++;
                check_eq("lock_core_noack", core_ack, 0);
                seen = host_ack;
            end
            check_eq("lock_burst_ack", seen, 1);
            check_eq("lock_burst_spacing", waited, (i == 0) ? 2 : 3);
            shadow[8'(8'h20 + i)] = 8'(i + 1);
            if (i < 3) drive_port(1, 1, 1, 8'(8'h21 + i), 8'(i + 2));
            else begin
                host_req = 1'b0;
                host_lock = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("lock_core_issue", {owner, mem_r_en}, 2'b01);
        check_eq("lock_core_addr", mem_addr, 8'h22);
        @(negedge clk);
        check_eq("lock_core_ack", core_ack, 1);
        check_eq("lock_core_rdata", core_rdata, 8'h03);
        held[0] = 8'h03;
        core_req = 1'b0;
        @(negedge clk);
        check_eq("lock_idle", busy, 0);

        // Reset in the ISSUE cycle of a core load.
        drive_port(0, 1, 0, 8'h10, 8'h00);
        @(negedge clk);
        check_eq("mid_issue_busy", busy, 1);
        init = 1'b1;
        #1;
        check_eq("mid_busy_drop", busy, 0);
        check_eq("mid_ren_drop", mem_r_en, 0);
        check_eq("mid_ack_drop", core_ack, 0);
        core_req = 1'b0;
        @(negedge clk);
        init = 1'b0;
        held[0] = '0;
        held[1] = '0;
        check_eq("mid_hold_cleared", core_rdata, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("mid_no_ack", {core_ack, host_ack, busy}, 0);
        end
        do_access(0, 0, 8'h10, 8'h00);

        // Single-port back-to-back loads: acks 3 cycles apart.
        addrs[0] = 8'h10; addrs[1] = 8'h04; addrs[2] = 8'h03;
        for (int i = 0; i < 3; i++) exp_rd[i] = shadow[addrs[i]];
        idx = 0;
        drive_port(0, 1, 0, addrs[0], 8'h00);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_eq("b2b_ack", core_ack, (k == 2) || (k == 5) || (k == 8));
            if (core_ack && idx < 3) begin
                check_eq("b2b_rdata", core_rdata, exp_rd[idx]);
                held[0] = exp_rd[idx];
                idx++;
                if (idx < 3) core_addr = addrs[idx];
                else core_req = 1'b0;
            end
        end
        check_eq("b2b_count", idx, 3);

        // Randomized two-master traffic against the shadow memory.
        do_reset();
        pend[0] = 0; pend[1] = 0; wt[0] = 0; wt[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                a_l  = p[0] ? host_ack : core_ack;
                rd_l = p[0] ? host_rdata : core_rdata;
                if (a_l) begin
                    check_eq("rnd_ack_pending", pend[p], 1);
                    if (r_we[p]) begin
                        check_eq("rnd_store_rdata", rd_l, held[p]);
                        shadow[r_addr[p]] = r_wdata[p];
                    end else begin
                        check_eq("rnd_load_rdata", rd_l, shadow[r_addr[p]]);
                        held[p] = shadow[r_addr[p]];
                    end
                    pend[p] = 0;
                end else begin
                    check_eq("rnd_hold", rd_l, held[p]);
                    if (pend[p]) begin
                        wt[p]++;
                        if (wt[p] > 4) begin
                            check_eq("rnd_wait_bound", wt[p], 4);
                            pend[p] = 0;
                        end
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]    = 1;
                    wt[p]      = 0;
                    r_we[p]    = 1'($urandom_range(0, 1));
                    r_addr[p]  = 8'(8'h40 + $urandom_range(0, 7));
                    r_wdata[p] = 8'($urandom_range(0, 255));
                end
                drive_port(p[0], pend[p], r_we[p], r_addr[p], r_wdata[p]);
            end
        end
        core_req = 1'b0; host_req = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check_eq("rnd_final_idle", busy, 0);

        // Host-priority instance: both continuous, host granted first then alternation.
        p_core_req = 1'b1; p_host_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq("prio_host_ack", p_host_ack, (k % 4) == 2);
            check_eq("prio_core_ack", p_core_ack, (k % 4) == 0);
            if (k % 4 == 1) check_eq("prio_owner", p_owner, 1);
            if (k % 4 == 3) check_eq("prio_owner", p_owner, 0);
        end
        p_core_req = 1'b0; p_host_req = 1'b0;
        @(negedge clk);
        check_eq("prio_idle", p_busy, 0);
        p_host_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq("prio_host_solo", p_host_ack, (k == 2) || (k == 5) || (k == 8));
        end
        p_host_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
